ex_mem_pipe_reg: RTL

Parametrised EX->MEM pipeline register, the successor to the fixed-width EX/MEM flip-flop stage. It adds a valid/ready handshake, a one-entry skid buffer for full-throughput backpressure, a synchronous flush, bubble insertion and a stall-cycle counter. It sits between the ALU/execute stage and the data-memory stage and carries the ALU result, store data, one-hot destination select and control flags (SW, LW, BEQ, BNE, BLT, BGE, zcomp, nzcomp).

---
 rtl/ex_mem_pkg.sv | 24 ++
 rtl/pipe_entry_reg.sv | 41 ++++
 rtl/ex_mem_pipe_reg.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM pipeline register: state encoding,
// control-flag bit positions and the default bubble destination select.
package ex_mem_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_e;

   // Control flag bit order {nzcomp, zcomp, BGE, BLT, BNE, BEQ, LW, SW}
   localparam int unsigned CTRL_SW     = 0;
   localparam int unsigned CTRL_LW     = 1;
   localparam int unsigned CTRL_BEQ    = 2;
   localparam int unsigned CTRL_BNE    = 3;
   localparam int unsigned CTRL_BLT    = 4;
   localparam int unsigned CTRL_BGE    = 5;
   localparam int unsigned CTRL_ZCOMP  = 6;
   localparam int unsigned CTRL_NZCOMP = 7;

   // Bubble writes target the hardwired-zero register r31
   localparam logic [31:0] BUBBLE_DSEL_DEF = 32'h8000_0000;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload entry (ALU result, store data, Dsel, control) with load,
// clear-to-bubble and synchronous reset; used for both main and skid slots.
module pipe_entry_reg #(
   parameter int unsigned            DATA_W      = 64,
   parameter int unsigned            DSEL_W      = 32,
   parameter int unsigned            CTRL_W      = 8,
   parameter logic [DSEL_W-1:0]      BUBBLE_DSEL = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] nxt_daddr,
   input  logic [DATA_W-1:0] nxt_data,
   input  logic [DSEL_W-1:0] nxt_dsel,
   input  logic [CTRL_W-1:0] nxt_ctrl,
   output logic [DATA_W-1:0] daddr,
   output logic [DATA_W-1:0] data,
   output logic [DSEL_W-1:0] dsel,
   output logic [CTRL_W-1:0] ctrl
);

   // Clearing only bubbles the side-effecting fields; address/data hold
   always_ff @(posedge clk) begin
      if (reset) begin
         daddr <= '0;
         data  <= '0;
         dsel  <= BUBBLE_DSEL;
         ctrl  <= '0;
      end else if (clear) begin
         dsel  <= BUBBLE_DSEL;
         ctrl  <= '0;
      end else if (load) begin
         daddr <= nxt_daddr;
         data  <= nxt_data;
         dsel  <= nxt_dsel;
         ctrl  <= nxt_ctrl;
      end
   end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, one-entry skid
// buffer, synchronous flush, bubble insertion and a saturating stall counter.
module ex_mem_pipe_reg
   import ex_mem_pkg::*;
#(
   parameter int unsigned       DATA_W      = 64,
   parameter int unsigned       DSEL_W      = 32,
   parameter int unsigned       CTRL_W      = 8,
   parameter logic [DSEL_W-1:0] BUBBLE_DSEL = DSEL_W'(BUBBLE_DSEL_DEF),
   parameter int unsigned       CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] ex_alu_out,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [DSEL_W-1:0] ex_dsel,
   input  logic [CTRL_W-1:0] ex_ctrl,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [DATA_W-1:0] mem_daddr,
   output logic [DATA_W-1:0] mem_data,
   output logic [DSEL_W-1:0] mem_dsel,
   output logic [CTRL_W-1:0] mem_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   pipe_state_e state, state_next;

   logic accept, drain;
   logic main_load, main_clear, skid_load, skid_clear;

   logic [DATA_W-1:0] skid_daddr, skid_data;
   logic [DSEL_W-1:0] skid_dsel;
   logic [CTRL_W-1:0] skid_ctrl;

   logic [DATA_W-1:0] main_nxt_daddr, main_nxt_data;
   logic [DSEL_W-1:0] main_nxt_dsel;
   logic [CTRL_W-1:0] main_nxt_ctrl;

   assign ex_ready  = (state != SKID);
   assign mem_valid = (state != EMPTY);
   assign accept    = ex_valid & ex_ready;
   assign drain     = mem_valid & mem_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         state_next = EMPTY;
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               main_load  = 1'b1;
               state_next = FULL;
            end
            FULL: begin
               if (accept && drain) begin
                  main_load  = 1'b1;
               end else if (accept) begin
                  skid_load  = 1'b1;
                  state_next = SKID;
               end else if (drain) begin
                  main_clear = 1'b1;
                  state_next = EMPTY;
               end
            end
            SKID: if (drain) begin
               main_load  = 1'b1;
               skid_clear = 1'b1;
               state_next = FULL;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // The skid entry is always older than the live input, so it refills main first
   always_comb begin
      if (state == SKID) begin
         main_nxt_daddr = skid_daddr;
         main_nxt_data  = skid_data;
         main_nxt_dsel  = skid_dsel;
         main_nxt_ctrl  = skid_ctrl;
      end else begin
         main_nxt_daddr = ex_alu_out;
         main_nxt_data  = ex_store_data;
         main_nxt_dsel  = ex_dsel;
         main_nxt_ctrl  = ex_ctrl;
      end
   end

   pipe_entry_reg #(
      .DATA_W      (DATA_W),
      .DSEL_W      (DSEL_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_DSEL (BUBBLE_DSEL)
   ) u_main (
      .clk       (clk),
      .reset     (reset),
      .load      (main_load),
      .clear     (main_clear),
      .nxt_daddr (main_nxt_daddr),
      .nxt_data  (main_nxt_data),
      .nxt_dsel  (main_nxt_dsel),
      .nxt_ctrl  (main_nxt_ctrl),
      .daddr     (mem_daddr),
      .data      (mem_data),
      .dsel      (mem_dsel),
      .ctrl      (mem_ctrl)
   );

   pipe_entry_reg #(
      .DATA_W      (DATA_W),
      .DSEL_W      (DSEL_W),
      .CTRL_W      (CTRL_W),
      .BUBBLE_DSEL (BUBBLE_DSEL)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .nxt_daddr (ex_alu_out),
      .nxt_data  (ex_store_data),
      .nxt_dsel  (ex_dsel),
      .nxt_ctrl  (ex_ctrl),
      .daddr     (skid_daddr),
      .data      (skid_data),
      .dsel      (skid_dsel),
      .ctrl      (skid_ctrl)
   );

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (mem_valid && !mem_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule
